iterative_shift_controller: RTL and testbench

- Multi-cycle barrel-shift replacement for the ALU.
- Accepts a 32-bit operand, a 5-bit shift amount and a direction.
- Applies one single-bit shift step per clock until the requested amount is reached, then presents the result with a done pulse.
- Lets the ALU offer SLL/SRA without a 32×5 barrel shifter; the ALU sequencer drives it over a ready/start handshake.

---
 rtl/iterative_shift_controller_pkg.sv | 19 +
 rtl/iterative_shift_controller_if.sv | 32 +++
 rtl/iterative_shift_controller_one_bit_shifter.sv | 19 +
 rtl/iterative_shift_controller.sv | 87 ++++++++
 tb/tb_iterative_shift_controller.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/iterative_shift_controller_pkg.sv
// Shared definitions for the iterative shift controller.
// Holds the operand and shift-amount widths, the controller state
// encoding, and the direction codes. The direction codes match the
// select polarity of the one-bit step stage.
package iterative_shift_controller_pkg;

  localparam int SHIFT_WIDTH   = 32;
  localparam int SHIFT_SHAMT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic DIR_SLL = 1'b0;
  localparam logic DIR_SRA = 1'b1;

endpackage

// File: rtl/iterative_shift_controller_if.sv
// Request/response bundle between the ALU sequencer (master) and the
// iterative shift controller (slave).
//   start/data_in/shamt/dir : request; sampled only on an accepted start
//   abort                   : synchronous cancel, takes priority over start
//   ready/busy              : controller status
//   done                    : one-cycle pulse on entry to DONE
//   result_valid/result     : completed shift value, held until the next
//                             accepted start or abort
interface iterative_shift_controller_if
  import iterative_shift_controller_pkg::*;
();
  logic                     start;
  logic [SHIFT_WIDTH-1:0]   data_in;
  logic [SHIFT_SHAMT_W-1:0] shamt;
  logic                     dir;
  logic                     abort;
  logic                     ready;
  logic                     busy;
  logic                     done;
  logic                     result_valid;
  logic [SHIFT_WIDTH-1:0]   result;

  modport master (
    output start, data_in, shamt, dir, abort,
    input  ready, busy, done, result_valid, result
  );

  modport slave (
    input  start, data_in, shamt, dir, abort,
    output ready, busy, done, result_valid, result
  );
endinterface

// File: rtl/iterative_shift_controller_one_bit_shifter.sv
// one_bit_shifter: single-step shift stage, a 32-bit 2:1 mux.
//   a      : value to shift
//   d      : DIR_SLL shifts left by one (zero fill),
//            DIR_SRA shifts right by one (sign fill)
//   result : shifted value
module one_bit_shifter
  import iterative_shift_controller_pkg::*;
(
  input  logic [SHIFT_WIDTH-1:0] a,
  input  logic                   d,
  output logic [SHIFT_WIDTH-1:0] result
);

  always_comb begin
    if (d == DIR_SRA) result = {a[SHIFT_WIDTH-1], a[SHIFT_WIDTH-1:1]};
    else              result = {a[SHIFT_WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/iterative_shift_controller.sv
// iterative_shift_controller: multi-cycle replacement for a barrel
// shifter. It takes a 32-bit operand, a 5-bit amount and a direction
// (logical left or arithmetic right). It applies one single-bit step per
// clock, then holds the result with a done pulse.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of iterative_shift_controller_if
module iterative_shift_controller
  import iterative_shift_controller_pkg::*;
#(
  parameter int WIDTH   = SHIFT_WIDTH,   // only 32 is supported
  parameter int SHAMT_W = SHIFT_SHAMT_W  // log2(WIDTH)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  iterative_shift_controller_if.slave   bus
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   step_out;
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_q;
  logic               done_q;
  logic               accept;

  one_bit_shifter u_step (
    .a      (acc_q),
    .d      (dir_q),
    .result (step_out)
  );

  // abort beats start, so a start that coincides with abort is never
  // accepted.
  assign accept = bus.ready && bus.start && !bus.abort;

  always_comb begin
    // NOTE: every output of this block gets a value before the case, so no
    // path can leave one unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.abort)   state_d = S_IDLE;
        else if (accept) state_d = (bus.shamt != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (bus.abort)                      state_d = S_IDLE;
        else if (cnt_q == SHAMT_W'(1))      state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready        = (state_q == S_IDLE) || (state_q == S_DONE);
    bus.busy         = (state_q == S_SHIFT);
    bus.result_valid = (state_q == S_DONE);
    bus.done         = done_q;
    bus.result       = acc_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_SLL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Pulse on every entry to DONE. A zero-amount start taken while
      // already in DONE re-enters DONE and also counts as an entry.
      done_q  <= (state_d == S_DONE) && ((state_q != S_DONE) || accept);
      if (accept) begin
        acc_q <= bus.data_in;
        cnt_q <= bus.shamt;
        dir_q <= bus.dir;
      end else if ((state_q == S_SHIFT) && !bus.abort) begin
        acc_q <= step_out;
        cnt_q <= cnt_q - SHAMT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_iterative_shift_controller.sv
// Self-checking bench for iterative_shift_controller. The stimulus side
// pushes the expected result and completion cycle for each tracked
// operation into a queue. A monitor pops one entry for each done pulse.
// Expected values come from plain shift operators applied to the operands.
module tb_iterative_shift_controller;

  logic clock;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  iterative_shift_controller_if bus ();

  iterative_shift_controller dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int unsigned s, input logic dr);
    if (dr) return 32'($signed(d) >>> s);
    return d << s;
  endfunction

  // Monitor: each done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", bus.done, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", bus.result, e.res);
        check("result_valid_with_done", bus.result_valid, 1'b1);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Waits for ready, presents one start for a single cycle, and optionally
  // records the expected completion.
  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic dr, input bit track);
    int guard;
    guard = 0;
    while (!bus.ready && guard < 100) begin
      step();
      guard++;
    end
    if (!bus.ready) check("ready_timeout", bus.ready, 1'b1);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.shamt   = s;
    bus.dir     = dr;
    step();
    bus.start   = 1'b0;
    bus.data_in = $urandom;
    bus.shamt   = 5'($urandom);
    bus.dir     = 1'($urandom);
    if (track) exp_q.push_back('{res: ref_shift(d, s, dr), cyc: cyc + int'(s)});
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      step();
      guard++;
    end
    check("drain_pending", exp_q.size(), 0);
    step();
  endtask

  initial begin
    int n;
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.data_in   = '0;
    bus.shamt     = '0;
    bus.dir       = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_ready", bus.ready, 1'b1);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_result_valid", bus.result_valid, 1'b0);
    check("reset_result", bus.result, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Left shift by 4, with the busy window counted.
    issue(32'h0000_0001, 5'd4, 1'b0, 1'b1);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      step();
    end
    check("sll4_busy_cycles", n, 4);
    drain();

    // Arithmetic right by the maximum amount, sign set and clear.
    issue(32'h8000_0000, 5'd31, 1'b1, 1'b1);
    issue(32'h7FFF_FFFF, 5'd31, 1'b1, 1'b1);
    drain();

    // Zero amount, then back-to-back start in the done cycle.
    issue(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1);
    issue(32'h0000_00F0, 5'd4, 1'b1, 1'b1);
    drain();

    // Start while busy is ignored.
    issue(32'h1234_5678, 5'd8, 1'b0, 1'b1);
    step();
    check("ready_low_when_busy", bus.ready, 1'b0);
    bus.start   = 1'b1;
    bus.data_in = 32'hFFFF_0000;
    bus.shamt   = 5'd3;
    bus.dir     = 1'b1;
    step();
    bus.start   = 1'b0;
    drain();

    // Abort in cycle 3 of an operation: no done, back to IDLE.
    issue(32'hCAFE_F00D, 5'd10, 1'b1, 1'b0);
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_ready", bus.ready, 1'b1);
    check("abort_result_valid", bus.result_valid, 1'b0);
    check("abort_done", bus.done, 1'b0);
    repeat (12) step();

    // Abort and start together: start is dropped.
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    bus.data_in = 32'h1111_2222;
    bus.shamt   = 5'd0;
    step();
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    check("abort_start_done", bus.done, 1'b0);
    check("abort_start_result_valid", bus.result_valid, 1'b0);
    check("abort_start_busy", bus.busy, 1'b0);

    // Asynchronous reset in the middle of an operation.
    issue(32'h0F0F_0F0F, 5'd10, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_ready", bus.ready, 1'b1);
    check("midreset_busy", bus.busy, 1'b0);
    check("midreset_done", bus.done, 1'b0);
    check("midreset_result_valid", bus.result_valid, 1'b0);
    check("midreset_result", bus.result, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    issue(32'hA5A5_0000, 5'd10, 1'b1, 1'b1);
    drain();

    // Random back-to-back operations.
    for (int i = 0; i < 40; i++) begin
      issue($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'b1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
